conv_mac_sequencer: RTL
=======================

# conv_mac_sequencer

Sequencer that time-shares one combinational signed 8x8 multiplier across the taps of a convolution kernel. It holds TAPS signed 8-bit coefficients and accepts a stream of signed 8-bit pixels. Each pixel is multiplied by the coefficient for its tap through a one-stage operand pipeline. Products are accumulated per window, and one result per TAPS pixels is emitted on a valid/ready output. The block sits between the window/line-buffer logic and the pixel output stage, and owns the only multiplier instance.

## Interface
- TAPS, 9, pixels per window (kernel size); 2..256
- ACC_W, 20, accumulator/result width; must be >= 16 + ceil(log2(TAPS))
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort: drop partial window, go to IDLE
- coef_we  in  1  coefficient write strobe
- coef_addr  in  8  coefficient index (0..TAPS-1)
- coef_data  in  8  signed coefficient
- pix_valid  in  1  pixel offered
- pix_ready  out  1  pixel accepted when valid&ready
- pix_data  in  8  signed pixel
- mul_a  out  8  multiplier operand A (registered pixel)
- mul_b  out  8  multiplier operand B (registered coefficient)
- mul_p  in  16  signed product from external multiplier, combinational from mul_a/mul_b
- res_valid  out  1  result available
- res_ready  in  1  result consumed when valid&ready
- res_data  out  ACC_W  signed window sum
- busy  out  1  high in any state but IDLE
- win_cnt  out  16  count of results delivered, saturates at 0xFFFF

## Operation
- Reset values: pix_ready=0 during reset; res_valid=0, res_data=0, mul_a=0, mul_b=0, busy=0, win_cnt=0; tap=0; acc=0; op_valid=0; coefficients=0.
- States:
  - IDLE: pix_ready=1.
  - ACCUM: pix_ready=1.
  - DRAIN: pix_ready=0.
  - OUT: pix_ready=0, res_valid=1.
- IDLE -> ACCUM on the first pixel handshake. This is tap 0, and acc is cleared on that cycle.
- ACCUM: each handshake latches mul_a<=pix_data, mul_b<=coef[tap], op_valid<=1, then increments tap.
  - If the handshake is on tap TAPS-1: tap<=0 and the state goes to DRAIN.
- Accumulate stage: when op_valid=1, acc <= acc + sext(mul_p). Product arithmetic is two's complement with sign-extension to ACC_W; no overflow is possible under the ACC_W rule.
- DRAIN (one cycle): the last product is accumulated, res_data <= final sum, and the state goes to OUT.
- OUT: res_data and res_valid hold stable until res_ready.
  - On the handshake, win_cnt is incremented (saturating) and the state goes to IDLE.
- Coefficient writes take effect only in IDLE, and only with coef_addr < TAPS. All other writes are silently ignored.
- flush: the highest-priority synchronous event. It takes effect from any state:
  - state<=IDLE, tap=0, op_valid=0, acc=0, res_valid=0
  - coefficients and win_cnt are kept
  - a pixel offered in the same cycle is not accepted (pix_ready forced 0 while flush=1).
- Reset mid-window: all state returns to reset values and coefficients clear to 0.

## Timing
- A pixel is accepted on cycle c. Its operands appear on mul_a/mul_b in cycle c+1, and its product is accumulated at the edge ending c+1.
- Last pixel accepted on cycle N: DRAIN is cycle N+1, and res_valid is high from cycle N+2.
- Minimum window period is TAPS+2 cycles with res_ready tied high:
  - TAPS accept cycles
  - 1 DRAIN cycle
  - 1 OUT cycle
- An IDLE cycle is skipped if a pixel is offered in the cycle after the OUT handshake.
- Pixel throughput is 1 per cycle inside a window. There are no bubbles while pix_valid stays high.
- Windows are never overlapped, and pix_ready is low in DRAIN and OUT.
- mul_p must settle within one cycle of mul_a/mul_b changing. There is no multicycle path.

## Configuration
- CONV_RELU_EN defined:
  - the final sum is clamped at DRAIN: res_data = (sum < 0) ? 0 : sum
  - win_cnt behaviour is unchanged.
- Undefined: res_data is the raw signed sum.

## Test plan
- All coef=1, pixels 1..9, res_ready=1 -> res_data=45, res_valid at cycle N+2, win_cnt=1.
- All coef=-128, pixels all -128 -> res_data=147456 (0x24000). Checks signed path and width.
- coef=-1, pixels all 127 -> res_data=-1143 (0xFFB89 at ACC_W=20) without CONV_RELU_EN; res_data=0 with CONV_RELU_EN.
- res_ready low 5 cycles in OUT, pix_valid held high -> res_data stable, pix_ready=0 throughout. The next window starts only after the handshake.
- Coef write to addr 0 while in ACCUM, and write to addr 9 in IDLE (TAPS=9) -> both ignored, result unchanged from baseline.
- flush after 4 pixels, then a full window of pixels 1..9 with coef=1 -> exactly one result, 45. Same sequence with rst_n pulsed instead of flush -> all outputs at reset values and result 0 (coefficients cleared).

Source files
------------

// File: rtl/conv_mac_sequencer.sv
// rtl/conv_mac_sequencer.sv - time-shared signed MAC sequencer for a TAPS-tap convolution kernel
//
// Feeds one external combinational 8x8 signed multiplier (mul_a/mul_b -> mul_p)
// with a registered pixel and its tap coefficient, accumulates the products of
// one window and presents the window sum on a valid/ready result port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort of the current window (coefs and win_cnt kept)
//   coef_we/addr/data     coefficient write, honoured only in IDLE with addr < TAPS
//   pix_valid/ready/data  signed 8-bit pixel stream
//   mul_a, mul_b, mul_p   operands to and product from the shared multiplier
//   res_valid/ready/data  signed ACC_W-bit window sum
//   busy                  high whenever not IDLE
//   win_cnt               saturating count of delivered results
//
// Build option: define CONV_RELU_EN to clamp negative window sums to zero.

module conv_mac_sequencer #(
   parameter int TAPS  = 9,
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             coef_we,
   input  logic [7:0]       coef_addr,
   input  logic [7:0]       coef_data,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic [7:0]       pix_data,
   output logic [7:0]       mul_a,
   output logic [7:0]       mul_b,
   input  logic [15:0]      mul_p,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_data,
   output logic             busy,
   output logic [15:0]      win_cnt
);

   localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [TAP_W-1:0]   tap;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   sum;
   logic [ACC_W-1:0]   final_sum;
   logic               op_valid;
   logic [7:0]         coef [TAPS];
   logic               pix_hs;
   logic               res_hs;
   logic               last_tap;
   logic               coef_ok;
   logic [TAP_W-1:0]   coef_idx;

   // Running sum including the product currently on the multiplier.
   assign sum      = acc + {{(ACC_W-16){mul_p[15]}}, mul_p};
   assign last_tap = (tap == TAP_W'(TAPS - 1));
   assign coef_idx = coef_addr[TAP_W-1:0];
   assign coef_ok  = coef_we && (state == IDLE) && !flush && (int'(coef_addr) < TAPS);

`ifdef CONV_RELU_EN
   assign final_sum = sum[ACC_W-1] ? '0 : sum;
`else
   assign final_sum = sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      pix_ready = 1'b0;
      res_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:    pix_ready = 1'b1;
         ACCUM:   pix_ready = 1'b1;
         DRAIN:   pix_ready = 1'b0;
         OUT:     res_valid = 1'b1;
         default: pix_ready = 1'b0;
      endcase
      // No pixel may be taken while flushing or while reset is asserted.
      pix_ready = pix_ready && !flush && rst_n;
      pix_hs    = pix_valid && pix_ready;
      res_hs    = res_valid && res_ready;
      case (state)
         IDLE:    if (pix_hs) state_nx = ACCUM;
         ACCUM:   if (pix_hs && last_tap) state_nx = DRAIN;
         DRAIN:   state_nx = OUT;
         OUT:     if (res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap      <= '0;
         acc      <= '0;
         op_valid <= 1'b0;
         mul_a    <= '0;
         mul_b    <= '0;
         res_data <= '0;
         win_cnt  <= '0;
         for (int i = 0; i < TAPS; i++) coef[i] <= '0;
      end else if (flush) begin
         tap      <= '0;
         acc      <= '0;
         op_valid <= 1'b0;
      end else begin
         op_valid <= 1'b0;
         if (op_valid) acc <= sum;
         if (pix_hs) begin
            mul_a    <= pix_data;
            mul_b    <= coef[tap];
            op_valid <= 1'b1;
            tap      <= last_tap ? '0 : tap + TAP_W'(1);
            // First pixel of a window starts a fresh sum.
            if (state == IDLE) acc <= '0;
         end
         if (state == DRAIN) res_data <= final_sum;
         if (res_hs && (win_cnt != 16'hFFFF)) win_cnt <= win_cnt + 16'd1;
         if (coef_ok) coef[coef_idx] <= coef_data;
      end
   end

endmodule
